// File: rtl/myproject_gauss_stats_if.sv
// Stream bundle for myproject_gauss_stats: one pixel input stream and five
// result output streams. The names match the myproject netlist.
// slave: the statistics engine. master: the pixel source and result sink.
interface myproject_gauss_stats_if #(
  parameter int FP_TOTAL = 16
);
  logic [FP_TOTAL-1:0] conv2d_input_V_data_0_V_TDATA;
  logic                conv2d_input_V_data_0_V_TVALID;
  logic                conv2d_input_V_data_0_V_TREADY;

  logic [FP_TOTAL-1:0] layer15_out_V_data_0_V_TDATA;
  logic                layer15_out_V_data_0_V_TVALID;
  logic                layer15_out_V_data_0_V_TREADY;
  logic [FP_TOTAL-1:0] layer15_out_V_data_1_V_TDATA;
  logic                layer15_out_V_data_1_V_TVALID;
  logic                layer15_out_V_data_1_V_TREADY;
  logic [FP_TOTAL-1:0] layer15_out_V_data_2_V_TDATA;
  logic                layer15_out_V_data_2_V_TVALID;
  logic                layer15_out_V_data_2_V_TREADY;
  logic [FP_TOTAL-1:0] layer15_out_V_data_3_V_TDATA;
  logic                layer15_out_V_data_3_V_TVALID;
  logic                layer15_out_V_data_3_V_TREADY;
  logic [FP_TOTAL-1:0] layer15_out_V_data_4_V_TDATA;
  logic                layer15_out_V_data_4_V_TVALID;
  logic                layer15_out_V_data_4_V_TREADY;

  modport slave (
    input  conv2d_input_V_data_0_V_TDATA,
    input  conv2d_input_V_data_0_V_TVALID,
    output conv2d_input_V_data_0_V_TREADY,
    output layer15_out_V_data_0_V_TDATA,
    output layer15_out_V_data_0_V_TVALID,
    input  layer15_out_V_data_0_V_TREADY,
    output layer15_out_V_data_1_V_TDATA,
    output layer15_out_V_data_1_V_TVALID,
    input  layer15_out_V_data_1_V_TREADY,
    output layer15_out_V_data_2_V_TDATA,
    output layer15_out_V_data_2_V_TVALID,
    input  layer15_out_V_data_2_V_TREADY,
    output layer15_out_V_data_3_V_TDATA,
    output layer15_out_V_data_3_V_TVALID,
    input  layer15_out_V_data_3_V_TREADY,
    output layer15_out_V_data_4_V_TDATA,
    output layer15_out_V_data_4_V_TVALID,
    input  layer15_out_V_data_4_V_TREADY
  );

  modport master (
    output conv2d_input_V_data_0_V_TDATA,
    output conv2d_input_V_data_0_V_TVALID,
    input  conv2d_input_V_data_0_V_TREADY,
    input  layer15_out_V_data_0_V_TDATA,
    input  layer15_out_V_data_0_V_TVALID,
    output layer15_out_V_data_0_V_TREADY,
    input  layer15_out_V_data_1_V_TDATA,
    input  layer15_out_V_data_1_V_TVALID,
    output layer15_out_V_data_1_V_TREADY,
    input  layer15_out_V_data_2_V_TDATA,
    input  layer15_out_V_data_2_V_TVALID,
    output layer15_out_V_data_2_V_TREADY,
    input  layer15_out_V_data_3_V_TDATA,
    input  layer15_out_V_data_3_V_TVALID,
    output layer15_out_V_data_3_V_TREADY,
    input  layer15_out_V_data_4_V_TDATA,
    input  layer15_out_V_data_4_V_TVALID,
    output layer15_out_V_data_4_V_TREADY
  );
endinterface

// File: rtl/myproject_gauss_stats.sv
// Frame statistics engine: accumulates one OUT_ROWS x OUT_COLS frame and
// emits peak, peak col, peak row, scaled sum and above-threshold count.
// Ports: ap_clk, ap_rst_n (sync, active-low), ap_start/ap_done/ap_idle/
// ap_ready (ap_ctrl_hs), io (slave: pixel stream in, five result streams).
// Optional macro MYPROJECT_SUM_SAT_EN: saturate result 3 instead of wrap.
module myproject_gauss_stats #(
  parameter int FP_TOTAL  = 16,
  parameter int OUT_ROWS  = 48,
  parameter int OUT_COLS  = 48,
  parameter int SUM_SHIFT = 11,
  parameter int THRESH    = 50
) (
  input  logic ap_clk,
  input  logic ap_rst_n,
  input  logic ap_start,
  output logic ap_done,
  output logic ap_idle,
  output logic ap_ready,
  myproject_gauss_stats_if.slave io
);

  localparam int CW = $clog2(OUT_COLS);
  localparam int RW = $clog2(OUT_ROWS);
  localparam logic signed [FP_TOTAL-1:0] THR =
    FP_TOTAL'(THRESH);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RUN,
    S_FIN,
    S_OUT,
    S_DONE
  } state_t;

  state_t state_q;
  state_t state_d;

  logic [CW-1:0] col_q;
  logic [CW-1:0] pcol_q;
  logic [RW-1:0] row_q;
  logic [RW-1:0] prow_q;

  logic signed [FP_TOTAL-1:0] pix;
  logic signed [FP_TOTAL-1:0] peak_q;
  logic signed [FP_TOTAL-1:0] r3;
  logic signed [31:0]         sum_q;
  logic signed [31:0]         pix_ext;
  logic [FP_TOTAL-1:0]        cnt_q;

  logic [FP_TOTAL-1:0] res_q [5];
  logic [4:0]          vld_q;
  logic [4:0]          rdy;

  logic acc;
  logic first_pix;
  logic last_pix;
  logic hot;

  assign pix     = io.conv2d_input_V_data_0_V_TDATA;
  assign pix_ext = {{(32-FP_TOTAL){pix[FP_TOTAL-1]}}, pix};

  assign rdy = {io.layer15_out_V_data_4_V_TREADY,
                io.layer15_out_V_data_3_V_TREADY,
                io.layer15_out_V_data_2_V_TREADY,
                io.layer15_out_V_data_1_V_TREADY,
                io.layer15_out_V_data_0_V_TREADY};

  assign acc = (state_q == S_RUN) &&
               io.conv2d_input_V_data_0_V_TVALID;

  // Counters sit at the origin only for the first pixel of a frame.
  assign first_pix = (col_q == '0) && (row_q == '0);
  assign last_pix  = acc &&
                     (col_q == CW'(OUT_COLS - 1)) &&
                     (row_q == RW'(OUT_ROWS - 1));
  assign hot = pix > THR;

`ifdef MYPROJECT_SUM_SAT_EN
  localparam logic signed [31:0] SMAX =
    (32'sd1 <<< (FP_TOTAL - 1)) - 32'sd1;
  localparam logic signed [31:0] SMIN =
    -(32'sd1 <<< (FP_TOTAL - 1));

  logic signed [31:0] sum_sh;

  assign sum_sh = sum_q >>> SUM_SHIFT;

  always_comb begin
    r3 = sum_sh[FP_TOTAL-1:0];
    if (sum_sh > SMAX) begin
      r3 = SMAX[FP_TOTAL-1:0];
    end else if (sum_sh < SMIN) begin
      r3 = SMIN[FP_TOTAL-1:0];
    end
  end
`else
  assign r3 = FP_TOTAL'(sum_q >>> SUM_SHIFT);
`endif

  always_ff @(posedge ap_clk) begin
    if (!ap_rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: if (ap_start) state_d = S_RUN;
      S_RUN:  if (last_pix) state_d = S_FIN;
      S_FIN:  state_d = S_OUT;
      // Leave once every pending stream is accepted,
      // including acceptances in this same cycle.
      S_OUT:  if ((vld_q & ~rdy) == '0) state_d = S_DONE;
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    ap_idle  = 1'b0;
    ap_ready = 1'b0;
    ap_done  = 1'b0;
    io.conv2d_input_V_data_0_V_TREADY = 1'b0;
    unique case (state_q)
      S_IDLE: ap_idle  = 1'b1;
      S_RUN:  io.conv2d_input_V_data_0_V_TREADY = 1'b1;
      S_FIN:  ap_ready = 1'b1;
      S_OUT:  ;
      S_DONE: ap_done  = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge ap_clk) begin
    if (!ap_rst_n) begin
      col_q  <= '0;
      row_q  <= '0;
      pcol_q <= '0;
      prow_q <= '0;
      peak_q <= '0;
      sum_q  <= '0;
      cnt_q  <= '0;
      vld_q  <= '0;
      res_q  <= '{default: '0};
    end else begin
      if (state_q == S_IDLE && ap_start) begin
        col_q <= '0;
        row_q <= '0;
        sum_q <= '0;
        cnt_q <= '0;
      end
      if (acc) begin
        if (col_q == CW'(OUT_COLS - 1)) begin
          col_q <= '0;
          if (row_q == RW'(OUT_ROWS - 1)) begin
            row_q <= '0;
          end else begin
            row_q <= row_q + RW'(1);
          end
        end else begin
          col_q <= col_q + CW'(1);
        end
        sum_q <= sum_q + pix_ext;
        if (hot) begin
          cnt_q <= cnt_q + FP_TOTAL'(1);
        end
        // Strict compare: ties keep the earliest position.
        if (first_pix || pix > peak_q) begin
          peak_q <= pix;
          pcol_q <= col_q;
          prow_q <= row_q;
        end
      end
      if (state_q == S_FIN) begin
        res_q[0] <= peak_q;
        res_q[1] <= FP_TOTAL'(pcol_q);
        res_q[2] <= FP_TOTAL'(prow_q);
        res_q[3] <= r3;
        res_q[4] <= cnt_q;
        vld_q    <= '1;
      end else begin
        vld_q <= vld_q & ~rdy;
      end
    end
  end

  assign io.layer15_out_V_data_0_V_TDATA  = res_q[0];
  assign io.layer15_out_V_data_1_V_TDATA  = res_q[1];
  assign io.layer15_out_V_data_2_V_TDATA  = res_q[2];
  assign io.layer15_out_V_data_3_V_TDATA  = res_q[3];
  assign io.layer15_out_V_data_4_V_TDATA  = res_q[4];
  assign io.layer15_out_V_data_0_V_TVALID = vld_q[0];
  assign io.layer15_out_V_data_1_V_TVALID = vld_q[1];
  assign io.layer15_out_V_data_2_V_TVALID = vld_q[2];
  assign io.layer15_out_V_data_3_V_TVALID = vld_q[3];
  assign io.layer15_out_V_data_4_V_TVALID = vld_q[4];

endmodule

// File: tb/tb_myproject_gauss_stats.sv
// Bench for myproject_gauss_stats: table of frames with expected results,
// scoreboard queues per result stream, plus stall/reset/back-to-back runs.
module tb_myproject_gauss_stats;

  localparam int N = 48 * 48;

  logic ap_clk   = 1'b0;
  logic ap_rst_n = 1'b0;
  logic ap_start = 1'b0;
  logic ap_done;
  logic ap_idle;
  logic ap_ready;

  myproject_gauss_stats_if bus();

  myproject_gauss_stats dut (
    .ap_clk   (ap_clk),
    .ap_rst_n (ap_rst_n),
    .ap_start (ap_start),
    .ap_done  (ap_done),
    .ap_idle  (ap_idle),
    .ap_ready (ap_ready),
    .io       (bus)
  );

  always #5 ap_clk = ~ap_clk;

  logic [15:0] i_dat = '0;
  logic        i_vld = 1'b0;
  wire         i_rdy;
  logic [4:0]  o_rdy = '1;
  wire  [4:0]  o_vld;
  wire  [15:0] o_dat [5];

  assign bus.conv2d_input_V_data_0_V_TDATA  = i_dat;
  assign bus.conv2d_input_V_data_0_V_TVALID = i_vld;
  assign i_rdy = bus.conv2d_input_V_data_0_V_TREADY;

  assign bus.layer15_out_V_data_0_V_TREADY = o_rdy[0];
  assign bus.layer15_out_V_data_1_V_TREADY = o_rdy[1];
  assign bus.layer15_out_V_data_2_V_TREADY = o_rdy[2];
  assign bus.layer15_out_V_data_3_V_TREADY = o_rdy[3];
  assign bus.layer15_out_V_data_4_V_TREADY = o_rdy[4];
  assign o_vld = {bus.layer15_out_V_data_4_V_TVALID,
                  bus.layer15_out_V_data_3_V_TVALID,
                  bus.layer15_out_V_data_2_V_TVALID,
                  bus.layer15_out_V_data_1_V_TVALID,
                  bus.layer15_out_V_data_0_V_TVALID};
  assign o_dat[0] = bus.layer15_out_V_data_0_V_TDATA;
  assign o_dat[1] = bus.layer15_out_V_data_1_V_TDATA;
  assign o_dat[2] = bus.layer15_out_V_data_2_V_TDATA;
  assign o_dat[3] = bus.layer15_out_V_data_3_V_TDATA;
  assign o_dat[4] = bus.layer15_out_V_data_4_V_TDATA;

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int done_cnt = 0;
  int in_hs = 0;
  int hold_until = 0;
  bit rnd_rdy = 1'b0;

  logic [15:0] sbq [5][$];
  bit          prev_stall [5];
  logic [15:0] prev_dat [5];

  typedef struct {
    int               kind;
    int               mode;
    logic [4:0][15:0] exp;
  } vec_t;

  vec_t vecs [7];

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)",
               nm, act, exp, cyc);
    end
  endtask

  function automatic logic [4:0][15:0] mk(
    input logic [15:0] p, input logic [15:0] c, input logic [15:0] r,
    input logic [15:0] s, input logic [15:0] n);
    return {n, s, r, c, p};
  endfunction

  function automatic logic [15:0] pix(input int kind, input int r,
                                      input int c);
    case (kind)
      1: return (r == 5 && c == 7) ? 16'd100 : 16'd0;
      2: return 16'h7fff;
      3: return 16'hfffb;
      4: return ((r == 1 && c == 2) || (r == 3 && c == 4)) ? 16'd200 :
                (r == 40 && c == 47) ? 16'd60 : 16'd0;
      5: return 16'(r * 48 + c - 1000);
      6: return 16'h8000;
      default: return 16'd0;
    endcase
  endfunction

  always @(posedge ap_clk) cyc <= cyc + 1;

  always @(posedge ap_clk) begin
    #1;
    for (int k = 0; k < 5; k++) begin
      if (cyc < hold_until) o_rdy[k] = 1'b0;
      else if (rnd_rdy) o_rdy[k] = 1'($urandom_range(0, 1));
      else o_rdy[k] = 1'b1;
    end
  end

  always @(negedge ap_clk) begin
    for (int k = 0; k < 5; k++) begin
      if (prev_stall[k] && o_vld[k])
        chk($sformatf("stable%0d", k), o_dat[k], prev_dat[k]);
      if (o_vld[k] && o_rdy[k]) begin
        if (sbq[k].size() == 0)
          chk($sformatf("extra%0d", k), 1, 0);
        else
          chk($sformatf("res%0d", k), o_dat[k], sbq[k].pop_front());
      end
      prev_stall[k] = o_vld[k] && !o_rdy[k];
      prev_dat[k]   = o_dat[k];
    end
    if (ap_done) begin
      done_cnt++;
      for (int k = 0; k < 5; k++)
        chk($sformatf("done_early%0d", k), sbq[k].size(), 0);
    end
    if (i_vld && i_rdy) in_hs++;
  end

  task automatic tick();
    @(posedge ap_clk);
    #1;
  endtask

  task automatic run_frame(input int kind, input int mode,
                           input int npix, input logic [4:0][15:0] exp,
                           input bit push);
    int t;
    int i;
    bit hs;
    t = 0;
    while (!ap_idle && t < 20000) begin
      tick();
      t++;
    end
    chk("idle_wait", ap_idle, 1);
    if (push)
      for (int k = 0; k < 5; k++) sbq[k].push_back(exp[k]);
    ap_start = 1'b1;
    tick();
    ap_start = 1'b0;
    if (mode == 2) repeat (4608) tick();
    i = 0;
    t = 0;
    while (i < npix && t < 8 * npix + 100) begin
      i_vld = (mode == 1) ? ($urandom_range(0, 3) != 0) : 1'b1;
      i_dat = pix(kind, i / 48, i % 48);
      @(negedge ap_clk);
      hs = i_vld && i_rdy;
      tick();
      if (hs) i++;
      t++;
    end
    chk("pix_accept", i, npix);
    if (npix == N) begin
      // Keep offering junk: none of it may be taken.
      i_vld = 1'b1;
      i_dat = 16'h7ffe;
      chk("ready_pulse", ap_ready, 1);
      chk("tready_drop", i_rdy, 0);
      chk("vld_early", o_vld, 5'h00);
      tick();
      chk("vld_rise", o_vld, 5'h1f);
      chk("ready_once", ap_ready, 0);
    end else begin
      i_vld = 1'b0;
    end
  endtask

  task automatic finish_run(input int hs0, input int budget);
    int d0;
    int t;
    d0 = done_cnt;
    t = 0;
    while (done_cnt == d0 && t < budget) begin
      tick();
      t++;
    end
    i_vld = 1'b0;
    chk("done_seen", done_cnt - d0, 1);
    chk("idle_back", ap_idle, 1);
    chk("in_hs", in_hs - hs0, N);
    for (int k = 0; k < 5; k++)
      chk($sformatf("sb_empty%0d", k), sbq[k].size(), 0);
    repeat (3) tick();
    chk("done_once", done_cnt - d0, 1);
  endtask

  initial begin
    int hs0;
    int d0;
    vecs[0] = '{0, 0, mk(16'd0, 16'd0, 16'd0, 16'd0, 16'd0)};
    vecs[1] = '{1, 0, mk(16'd100, 16'd7, 16'd5, 16'd0, 16'd1)};
`ifdef MYPROJECT_SUM_SAT_EN
    vecs[2] = '{2, 0, mk(16'h7fff, 16'd0, 16'd0, 16'h7fff, 16'd2304)};
    vecs[6] = '{6, 0, mk(16'h8000, 16'd0, 16'd0, 16'h8000, 16'd0)};
`else
    vecs[2] = '{2, 0, mk(16'h7fff, 16'd0, 16'd0, 16'h8ffe, 16'd2304)};
    vecs[6] = '{6, 0, mk(16'h8000, 16'd0, 16'd0, 16'h7000, 16'd0)};
`endif
    vecs[3] = '{3, 0, mk(16'hfffb, 16'd0, 16'd0, 16'hfffa, 16'd0)};
    vecs[4] = '{4, 0, mk(16'd200, 16'd2, 16'd1, 16'd0, 16'd3)};
    vecs[5] = '{5, 1, mk(16'd1303, 16'd47, 16'd47, 16'd170, 16'd1253)};

    repeat (3) tick();
    chk("rst_idle", ap_idle, 1);
    chk("rst_done", ap_done, 0);
    chk("rst_ready", ap_ready, 0);
    chk("rst_tready", i_rdy, 0);
    chk("rst_vld", o_vld, 5'h00);
    for (int k = 0; k < 5; k++)
      chk($sformatf("rst_dat%0d", k), o_dat[k], 16'h0);
    ap_rst_n = 1'b1;
    tick();

    for (int v = 0; v < 7; v++) begin
      rnd_rdy = (v % 2) == 1;
      hs0 = in_hs;
      run_frame(vecs[v].kind, vecs[v].mode, N, vecs[v].exp, 1'b1);
      finish_run(hs0, 2000);
    end

    hold_until = cyc + 9216;
    rnd_rdy = 1'b1;
    hs0 = in_hs;
    run_frame(vecs[4].kind, 2, N, vecs[4].exp, 1'b1);
    chk("stall_hold", o_rdy, 5'h00);
    finish_run(hs0, 12000);

    rnd_rdy = 1'b0;
    run_frame(5, 0, 1000, vecs[5].exp, 1'b0);
    d0 = done_cnt;
    ap_rst_n = 1'b0;
    repeat (2) tick();
    chk("mid_rst_idle", ap_idle, 1);
    chk("mid_rst_vld", o_vld, 5'h00);
    chk("mid_rst_tready", i_rdy, 0);
    ap_rst_n = 1'b1;
    repeat (5) tick();
    chk("mid_rst_nodone", done_cnt - d0, 0);
    hs0 = in_hs;
    run_frame(vecs[1].kind, 0, N, vecs[1].exp, 1'b1);
    finish_run(hs0, 2000);

    rnd_rdy = 1'b1;
    d0 = done_cnt;
    for (int b = 0; b < 5; b++) begin
      hs0 = in_hs;
      run_frame(vecs[5].kind, 0, N, vecs[5].exp, 1'b1);
      finish_run(hs0, 2000);
    end
    chk("b2b_dones", done_cnt - d0, 5);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
